// File: rtl/pb_debounce_pair.sv
// Two-channel pushbutton conditioner: 2-FF synchroniser plus per-channel debounce FSM.
// Optional stuck-button detection is compiled in with PB_STUCK_DETECT_EN.
module pb_debounce_pair #(
    parameter int DB_CYCLES    = 50000,
    parameter int CNT_W        = 20,
    parameter int STUCK_CYCLES = 250000000
) (
    input  logic CLK_I,
    input  logic rst,
    input  logic btn_r_raw,
    input  logic btn_l_raw,
    output logic pbr,
    output logic pbl,
    output logic press_r,
    output logic press_l,
    output logic stuck_r,
    output logic stuck_l
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONF_PRESS = 2'd1,
        PRESSED    = 2'd2,
        CONF_REL   = 2'd3
    } state_t;

    // Elaboration-time guards on the configuration
    if ((DB_CYCLES < 32'sd2) || (DB_CYCLES > 32'sd1048576)) begin : g_bad_db
        $error("pb_debounce_pair: DB_CYCLES out of range");
    end
    if ((64'd1 << CNT_W) <= 64'(DB_CYCLES)) begin : g_bad_cnt_w
        $error("pb_debounce_pair: CNT_W too narrow for DB_CYCLES");
    end
    if (STUCK_CYCLES < 32'sd1) begin : g_bad_stuck
        $error("pb_debounce_pair: STUCK_CYCLES must be positive");
    end

    logic [1:0] raw_s;
    logic [1:0] sync1_r;
    logic [1:0] sync2_r;
    logic [1:0] level_v_s;
    logic [1:0] pulse_v_s;
    logic [1:0] stuck_v_s;

    // Index 0 is the right button, index 1 the left button
    assign raw_s = {btn_l_raw, btn_r_raw};

    // Two-stage synchroniser for both raw buttons
    always_ff @(posedge CLK_I) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t           state_r;
        state_t           state_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_s;
        logic             level_r;
        logic             level_s;
        logic             pulse_r;
        logic             pulse_s;
        logic             smp_s;
        logic             cnt_done_s;

        assign smp_s      = sync2_r[ch];
        assign cnt_done_s = (cnt_r == CNT_W'(DB_CYCLES - 1));

        // Next-state, counter and output decode for one channel
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            level_s = level_r;
            pulse_s = 1'b0;
            case (state_r)
                IDLE: begin
                    level_s = 1'b0;
                    if (smp_s) begin
                        state_s = CONF_PRESS;
                        cnt_s   = CNT_W'(1);
                    end else begin
                        cnt_s = {CNT_W{1'b0}};
                    end
                end
                CONF_PRESS: begin
                    if (!smp_s) begin
                        state_s = IDLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else if (cnt_done_s) begin
                        state_s = PRESSED;
                        cnt_s   = {CNT_W{1'b0}};
                        level_s = 1'b1;
                        pulse_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    level_s = 1'b1;
                    if (!smp_s) begin
                        state_s = CONF_REL;
                        cnt_s   = CNT_W'(1);
                    end else begin
                        cnt_s = {CNT_W{1'b0}};
                    end
                end
                CONF_REL: begin
                    if (smp_s) begin
                        state_s = PRESSED;
                        cnt_s   = {CNT_W{1'b0}};
                    end else if (cnt_done_s) begin
                        state_s = IDLE;
                        cnt_s   = {CNT_W{1'b0}};
                        level_s = 1'b0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    level_s = 1'b0;
                end
            endcase
        end

        // State, counter and registered outputs for one channel
        always_ff @(posedge CLK_I) begin
            if (rst) begin
                state_r <= IDLE;
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= 1'b0;
                pulse_r <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                level_r <= level_s;
                pulse_r <= pulse_s;
            end
        end

        assign level_v_s[ch] = level_r;
        assign pulse_v_s[ch] = pulse_r;

`ifdef PB_STUCK_DETECT_EN
        localparam int SW = $clog2(STUCK_CYCLES + 1);

        logic [SW-1:0] stk_cnt_r;
        logic [SW-1:0] stk_cnt_s;
        logic          stk_flag_r;

        // Held-time counter: runs while the level is high, saturates, clears on return to IDLE
        always_comb begin
            stk_cnt_s = stk_cnt_r;
            if (state_s == IDLE) begin
                stk_cnt_s = {SW{1'b0}};
            end else if (((state_r == PRESSED) || (state_r == CONF_REL)) &&
                         (stk_cnt_r != SW'(STUCK_CYCLES))) begin
                stk_cnt_s = stk_cnt_r + SW'(1);
            end else begin
                stk_cnt_s = stk_cnt_r;
            end
        end

        // Stuck counter and flag registers
        always_ff @(posedge CLK_I) begin
            if (rst) begin
                stk_cnt_r  <= {SW{1'b0}};
                stk_flag_r <= 1'b0;
            end else begin
                stk_cnt_r  <= stk_cnt_s;
                stk_flag_r <= (stk_cnt_s == SW'(STUCK_CYCLES));
            end
        end

        assign stuck_v_s[ch] = stk_flag_r;
`else
        assign stuck_v_s[ch] = 1'b0;
`endif
    end

    assign pbr     = level_v_s[0];
    assign pbl     = level_v_s[1];
    assign press_r = pulse_v_s[0];
    assign press_l = pulse_v_s[1];
    assign stuck_r = stuck_v_s[0];
    assign stuck_l = stuck_v_s[1];

endmodule
